// File: rtl/xbus_pkg.sv
// Shared xbus definitions for the SDRAM bridge.
// Contents: bus widths, the decode limit, the error read-back pattern and the
// bridge FSM state encoding.
package xbus_pkg;

  localparam int XBUS_ADDR_W = 22;
  localparam int XBUS_DATA_W = 32;

  // Addresses below this are claimed by the main-memory bridge.
  localparam logic [XBUS_ADDR_W-1:0] XBUS_DECODE_LIMIT = 22'o11000000;

  // Returned on reads of phantom addresses and on timed-out reads.
  localparam logic [XBUS_DATA_W-1:0] XBUS_BUS_ERR_DATA = 32'hffffffff;

  // Bridge FSM encoding (plain constants so legacy code can compare against them).
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_ACK   = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;

endpackage

// File: rtl/xbus_sdram_bridge.sv
// Xbus slave serving main memory through the external SDRAM controller.
// Each single-word xbus request becomes one sdram_req/sdram_ready/sdram_done
// handshake; decoded addresses beyond the backed DRAM are answered locally,
// and a stalled controller is aborted after TIMEOUT cycles with bus_err.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   addr, datain, req, write xbus request (req held until ack)
//   dataout, ack, bus_err   xbus response (ack/bus_err are one-cycle pulses)
//   decode                  combinational address claim
//   sdram_*                 controller request fields and handshake
module xbus_sdram_bridge
  import xbus_pkg::*;
#(
  parameter int unsigned            DRAM_SIZE    = 131072,
  parameter logic [XBUS_ADDR_W-1:0] DECODE_LIMIT = XBUS_DECODE_LIMIT,
  parameter logic [7:0]             TIMEOUT      = 8'd255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [XBUS_ADDR_W-1:0] addr,
  input  logic [XBUS_DATA_W-1:0] datain,
  input  logic                   req,
  input  logic                   write,
  output logic [XBUS_DATA_W-1:0] dataout,
  output logic                   ack,
  output logic                   decode,
  output logic                   bus_err,
  output logic [XBUS_ADDR_W-1:0] sdram_addr,
  output logic [XBUS_DATA_W-1:0] sdram_data_out,
  output logic                   sdram_write,
  output logic                   sdram_req,
  input  logic                   sdram_ready,
  input  logic [XBUS_DATA_W-1:0] sdram_data_in,
  input  logic                   sdram_done
);

  // One extra bit so a DRAM_SIZE of 2**XBUS_ADDR_W still compares correctly.
  localparam logic [XBUS_ADDR_W:0] DRAM_LIMIT = (XBUS_ADDR_W+1)'(DRAM_SIZE);

  logic [2:0]             state_q, state_d;
  logic [XBUS_ADDR_W-1:0] addr_q, addr_d;
  logic [XBUS_DATA_W-1:0] wdata_q, wdata_d;
  logic                   write_q, write_d;
  logic [XBUS_DATA_W-1:0] dataout_q, dataout_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   err_q, err_d;

  logic in_dram;

  assign decode  = (addr < DECODE_LIMIT);
  assign in_dram = ({1'b0, addr} < DRAM_LIMIT);

  always_comb begin
    // NOTE: every next-state variable gets its hold value first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    write_d   = write_q;
    dataout_d = dataout_q;
    cnt_d     = cnt_q;
    err_d     = err_q;

    case (state_q)
      ST_IDLE: begin
        if (req && decode) begin
          addr_d  = addr;
          wdata_d = datain;
          write_d = write;
          if (in_dram) begin
            state_d = ST_ISSUE;
          end else begin
            // Phantom: answer locally; writes simply vanish.
            state_d = ST_ACK;
            if (!write) dataout_d = XBUS_BUS_ERR_DATA;
          end
        end
      end

      ST_ISSUE: begin
        if (sdram_ready) begin
          if (sdram_done) begin
            if (!write_q) dataout_d = sdram_data_in;
            state_d = ST_ACK;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = '0;
          end
        end
      end

      ST_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (sdram_done) begin
          if (!write_q) dataout_d = sdram_data_in;
          state_d = ST_ACK;
        end else if (cnt_q == TIMEOUT) begin
          if (!write_q) dataout_d = XBUS_BUS_ERR_DATA;
          err_d   = 1'b1;
          state_d = ST_ACK;
        end
      end

      ST_ACK: begin
        err_d   = 1'b0;
        state_d = ST_HOLD;
      end

      // The master is still dropping req here; ignore it for one cycle.
      ST_HOLD: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      dataout_q <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      dataout_q <= dataout_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign ack            = (state_q == ST_ACK);
  assign bus_err        = ack && err_q;
  assign sdram_req      = (state_q == ST_ISSUE);
  assign sdram_addr     = addr_q;
  assign sdram_data_out = wdata_q;
  assign sdram_write    = write_q;
  assign dataout        = dataout_q;

endmodule

// File: tb/tb_xbus_sdram_bridge.sv
// Testbench for xbus_sdram_bridge: a table of transactions run against a
// small SDRAM controller model, expected responses queued at drive time and
// popped at ack, plus hand sequences for decode miss and reset mid-WAIT.
module tb_xbus_sdram_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [21:0] addr;
  logic [31:0] datain;
  logic        req;
  logic        write;
  logic [31:0] dataout;
  logic        ack;
  logic        decode;
  logic        bus_err;
  logic [21:0] sdram_addr;
  logic [31:0] sdram_data_out;
  logic        sdram_write;
  logic        sdram_req;
  logic        sdram_ready;
  logic [31:0] sdram_data_in;
  logic        sdram_done;

  localparam logic [31:0] JUNK = 32'h5a5a5a5a;

  xbus_sdram_bridge dut (
    .clk(clk), .reset(reset), .addr(addr), .datain(datain), .req(req),
    .write(write), .dataout(dataout), .ack(ack), .decode(decode),
    .bus_err(bus_err), .sdram_addr(sdram_addr),
    .sdram_data_out(sdram_data_out), .sdram_write(sdram_write),
    .sdram_req(sdram_req), .sdram_ready(sdram_ready),
    .sdram_data_in(sdram_data_in), .sdram_done(sdram_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // rdy_dly: extra ISSUE cycles before ready; done_dly: cycles from the ready
  // cycle to done (0 = same cycle, -1 = never). exp_lat is the ack cycle
  // counted from the request-sampling edge (cycle n follows edge n-1).
  typedef struct {
    string       name;
    logic [21:0] addr;
    logic        wr;
    logic [31:0] wdata;
    int          rdy_dly;
    int          done_dly;
    logic [31:0] rdata;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
    int          exp_issue;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
  } exp_t;

  vec_t vecs[12];
  exp_t exp_q[$];

  task automatic check_zero(input string tag);
    check({tag, "/ack"}, 32'(ack), 32'd0);
    check({tag, "/bus_err"}, 32'(bus_err), 32'd0);
    check({tag, "/sdram_req"}, 32'(sdram_req), 32'd0);
    check({tag, "/dataout"}, dataout, 32'd0);
    check({tag, "/sdram_addr"}, 32'(sdram_addr), 32'd0);
    check({tag, "/sdram_data_out"}, sdram_data_out, 32'd0);
    check({tag, "/sdram_write"}, 32'(sdram_write), 32'd0);
  endtask

  task automatic run_txn(input vec_t v);
    int   issue_cnt;
    int   accept_c;
    int   ack_c;
    logic bad_fields;
    exp_t e;
    issue_cnt  = 0;
    accept_c   = -1;
    ack_c      = -1;
    bad_fields = 1'b0;

    @(negedge clk);
    addr   = v.addr;
    write  = v.wr;
    datain = v.wdata;
    req    = 1'b1;
    exp_q.push_back('{data: v.exp_data, err: v.exp_err, lat: v.exp_lat});
    #1 check({v.name, "/decode"}, 32'(decode), 32'd1);
    @(posedge clk);  // request-sampling edge 0

    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      if (sdram_req) begin
        issue_cnt++;
        if (sdram_addr !== v.addr || sdram_write !== v.wr || sdram_data_out !== v.wdata)
          bad_fields = 1'b1;
      end
      if (ack) begin
        ack_c = c;
        break;
      end
      sdram_ready = sdram_req && (issue_cnt > v.rdy_dly);
      if (sdram_ready) accept_c = c;
      sdram_done    = (v.done_dly >= 0) && (accept_c >= 0) && (c == accept_c + v.done_dly);
      sdram_data_in = sdram_done ? v.rdata : JUNK;
      @(posedge clk);
    end
    sdram_ready   = 1'b0;
    sdram_done    = 1'b0;
    sdram_data_in = JUNK;

    if (exp_q.size() == 0) begin
      check({v.name, "/scoreboard_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({v.name, "/ack_cycle"}, 32'(ack_c), 32'(e.lat));
      check({v.name, "/dataout"}, dataout, e.data);
      check({v.name, "/bus_err"}, 32'(bus_err), 32'(e.err));
    end
    check({v.name, "/issue_cycles"}, 32'(issue_cnt), 32'(v.exp_issue));
    check({v.name, "/fields_stable"}, 32'(bad_fields), 32'd0);

    // HOLD: master drops req; the ack pulse must already be gone.
    @(negedge clk);
    req = 1'b0;
    check({v.name, "/ack_one_cycle"}, 32'(ack), 32'd0);
    check({v.name, "/dataout_held"}, dataout, e.data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_ack;
    int n_req;

    vecs[0]  = '{"rd_basic",     22'o100,      1'b0, 32'h00000000, 0,  3, 32'h12345678, 32'h12345678, 1'b0, 5,   1};
    vecs[1]  = '{"wr_ready_dly", 22'o200,      1'b1, 32'hdeadbeef, 3,  2, 32'h0badf00d, 32'h12345678, 1'b0, 7,   4};
    vecs[2]  = '{"rd_phantom",   22'o1000000,  1'b0, 32'h00000001, 0, -1, JUNK,         32'hffffffff, 1'b0, 1,   0};
    vecs[3]  = '{"rd_same_cyc",  22'o300,      1'b0, 32'h00000002, 0,  0, 32'ha5a50001, 32'ha5a50001, 1'b0, 2,   1};
    vecs[4]  = '{"wr_phantom",   22'o10777777, 1'b1, 32'h13572468, 0, -1, JUNK,         32'ha5a50001, 1'b0, 1,   0};
    vecs[5]  = '{"rd_at_dram",   22'o400000,   1'b0, 32'h00000003, 0, -1, JUNK,         32'hffffffff, 1'b0, 1,   0};
    vecs[6]  = '{"rd_last_word", 22'o377777,   1'b0, 32'h00000004, 1,  1, 32'hcafe0002, 32'hcafe0002, 1'b0, 4,   2};
    vecs[7]  = '{"rd_timeout",   22'o17,       1'b0, 32'h00000005, 0, -1, JUNK,         32'hffffffff, 1'b1, 258, 1};
    vecs[8]  = '{"rd_done_last", 22'o20,       1'b0, 32'h00000006, 0, 256, 32'h0bad0003, 32'h0bad0003, 1'b0, 258, 1};
    vecs[9]  = '{"wr_after_to",  22'o40,       1'b1, 32'h11112222, 0,  1, 32'h99999999, 32'h0bad0003, 1'b0, 3,   1};
    vecs[10] = '{"wr_post_rst",  22'o50,       1'b1, 32'h33334444, 1,  0, 32'h88887777, 32'h00000000, 1'b0, 3,   2};
    vecs[11] = '{"rd_post_rst",  22'o60,       1'b0, 32'h00000007, 0,  1, 32'h77778888, 32'h77778888, 1'b0, 3,   1};

    reset = 1'b1; req = 1'b0; write = 1'b0; addr = '0; datain = '0;
    sdram_ready = 1'b0; sdram_done = 1'b0; sdram_data_in = JUNK;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    reset = 1'b0;

    for (int i = 0; i < 10; i++) run_txn(vecs[i]);

    // Decode miss: never acknowledged, never forwarded, nothing captured.
    @(negedge clk);
    addr = 22'o11000000; write = 1'b0; datain = 32'hffff0000; req = 1'b1;
    #1 check("nodecode/decode", 32'(decode), 32'd0);
    n_ack = 0; n_req = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ack) n_ack++;
      if (sdram_req) n_req++;
    end
    check("nodecode/acks", 32'(n_ack), 32'd0);
    check("nodecode/sdram_reqs", 32'(n_req), 32'd0);
    check("nodecode/sdram_addr", 32'(sdram_addr), 32'(22'o40));
    req = 1'b0;

    // Reset while waiting on the controller, then a stray done.
    @(negedge clk);
    addr = 22'o100; write = 1'b0; datain = 32'h0; req = 1'b1;
    @(negedge clk);
    check("rstwait/issue", 32'(sdram_req), 32'd1);
    sdram_ready = 1'b1;
    @(negedge clk);
    sdram_ready = 1'b0;
    check("rstwait/in_wait", 32'(sdram_req), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1; req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sdram_done = 1'b1; sdram_data_in = 32'hdeadd00d;
    @(negedge clk);
    sdram_done = 1'b0; sdram_data_in = JUNK;
    n_ack = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (ack) n_ack++;
    end
    check("rstwait/acks", 32'(n_ack), 32'd0);
    check_zero("rstwait");

    for (int i = 10; i < 12; i++) run_txn(vecs[i]);

    check("scoreboard/leftover", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
